busperm_sched: RTL

Sequencing controller for the 8-lane × 3-bit bus permutator. It holds a small table of 16-bit permutation control words and streams data beats through the permutator, applying table entries in round-robin order over a programmable sequence length. Both the input stream and the output stream use a valid/ready handshake. The permutator sits combinationally between this block's input side and its output register.

---
 rtl/busperm_sched_if.sv | 20 ++
 rtl/busperm_sched.sv | 100 ++++++++++
 2 files changed

// File: rtl/busperm_sched_if.sv
// Input and output beat handshakes for the permutator sequencer.
// slave is the sequencer side, master is the producer/consumer side.
interface busperm_sched_if;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/busperm_sched.sv
// Streams beats through an external 8x3-bit permutator, applying table words round-robin.
// One-cycle latency, full throughput; input stalls while the output register is held.
module busperm_sched #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [15:0]         cfg_data,
    output logic                cfg_err,
    input  logic [AW-1:0]       seq_last,
    input  logic                start,
    input  logic                stop,
    output logic                busy,
    busperm_sched_if.slave      bus,
    output logic [23:0]         perm_din,
    output logic [15:0]         perm_ctrl,
    input  logic [23:0]         perm_dout,
    output logic [15:0]         seq_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [15:0]   tbl [DEPTH];
    logic [AW-1:0] ptr;
    logic [AW-1:0] last;
    logic          out_vld_q;
    logic [23:0]   out_dat_q;
    logic          in_rdy;
    logic          accept;
    logic          out_fire;
    logic          go;

    assign in_rdy    = (state == RUN) && (!out_vld_q || bus.out_ready);
    assign accept    = bus.in_valid && in_rdy;
    assign out_fire  = out_vld_q && bus.out_ready;
    // stop has priority over start when both are seen in IDLE
    assign go        = (state == IDLE) && start && !stop;

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld_q;
    assign bus.out_data  = out_dat_q;
    assign perm_din      = bus.in_data;
    assign perm_ctrl     = tbl[ptr];
    assign busy          = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = RUN;
            RUN:     if (stop) state_nxt = DRAIN;
            DRAIN:   if (!out_vld_q || bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            last      <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            seq_cnt   <= '0;
            cfg_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
        end else begin
            state   <= state_nxt;
            cfg_err <= cfg_we && (state != IDLE);
            if (cfg_we && (state == IDLE)) tbl[cfg_addr] <= cfg_data;

            if (go) begin
                ptr     <= '0;
                last    <= seq_last;
                seq_cnt <= '0;
            end

            if (accept) begin
                out_dat_q <= perm_dout;
                out_vld_q <= 1'b1;
                if (ptr == last) begin
                    ptr     <= '0;
                    seq_cnt <= seq_cnt + 16'd1;
                end else begin
                    ptr <= ptr + 1'b1;
                end
            end else if (out_fire) begin
                out_vld_q <= 1'b0;
            end
        end
    end

endmodule
